// File: rtl/img_pkg.sv
// Shared types and constants for the image SRAM loader.
// words_per_frame gives the number of SRAM writes needed to store one frame.
package img_pkg;

   localparam int PIX_W_DEF = 8;
   localparam int DIM_W_DEF = 13;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } loader_state_t;

   function automatic int words_per_frame(input int w, input int h, input int ppw);
      return (w * h + ppw - 1) / ppw;
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Modulo counter: counts 0..rollover_val-1 while enabled, then wraps to 0.
// rollover_flag is high while the count sits at its last value.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out,
   output logic                    rollover_flag
);

   logic [NUM_CNT_BITS-1:0] count_q, count_d;

   assign rollover_flag = (count_q == (rollover_val - NUM_CNT_BITS'(1)));
   assign count_out     = count_q;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         if (rollover_flag) count_d = '0;
         else               count_d = count_q + NUM_CNT_BITS'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/img_sram_loader.sv
// Packs a raster pixel stream into SRAM words and writes them sequentially
// from a base address, pulsing done once the whole frame has been stored.
//
// state | meaning
// IDLE  | waiting for start; configuration latched on an accepted start
// LOAD  | accepting pixels, issuing each full word
// FLUSH | last pixel taken; waiting for the final write to be accepted
// DONE  | one-cycle done pulse (err_size too for a zero-size frame)
module img_sram_loader
   import img_pkg::*;
#(
   parameter int PIX_W        = PIX_W_DEF,
   parameter int PIX_PER_WORD = 4,
   parameter int ADDR_W       = 16,
   parameter int DIM_W        = DIM_W_DEF
) (
   input  logic                          clk,
   input  logic                          n_rst,
   input  logic                          start,
   input  logic [DIM_W-1:0]              img_width,
   input  logic [DIM_W-1:0]              img_height,
   input  logic [ADDR_W-1:0]             base_addr,
   input  logic                          pix_valid,
   input  logic [PIX_W-1:0]              pix_data,
   output logic                          pix_ready,
   input  logic                          sram_busy,
   output logic                          sram_wen,
   output logic [ADDR_W-1:0]             sram_addr,
   output logic [PIX_W*PIX_PER_WORD-1:0] sram_wdata,
   output logic [DIM_W-1:0]              col,
   output logic [DIM_W-1:0]              row,
   output logic                          busy,
   output logic                          done,
   output logic                          err_size
);

   localparam int WORD_W = PIX_W * PIX_PER_WORD;
   localparam int IDX_W  = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_PER_WORD - 1);

   loader_state_t      state_q, state_d;
   logic [DIM_W-1:0]   width_q, width_d;
   logic [DIM_W-1:0]   height_q, height_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [WORD_W-1:0]  pack_q, pack_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               wen_q, wen_d;
   logic               err_q, err_d;

   logic pix_accept;
   logic wr_accept;
   logic dims_ok;
   logic start_ok;
   logic col_wrap;
   logic row_wrap;
   logic last_pix;

   // wen_q doubles as the "word pending" flag: no pixel is taken while a word is outstanding
   assign pix_ready  = (state_q == LOAD) && !wen_q;
   assign pix_accept = pix_ready && pix_valid;
   assign wr_accept  = wen_q && !sram_busy;
   assign dims_ok    = (img_width != '0) && (img_height != '0);
   assign start_ok   = (state_q == IDLE) && start && dims_ok;
   assign last_pix   = col_wrap && row_wrap;

   flex_counter #(.NUM_CNT_BITS(DIM_W)) u_col_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (start_ok),
      .count_enable  (pix_accept),
      .rollover_val  (width_q),
      .count_out     (col),
      .rollover_flag (col_wrap)
   );

   flex_counter #(.NUM_CNT_BITS(DIM_W)) u_row_cnt (
      .clk           (clk),
      .n_rst         (n_rst),
      .clear         (start_ok),
      .count_enable  (pix_accept && col_wrap),
      .rollover_val  (height_q),
      .count_out     (row),
      .rollover_flag (row_wrap)
   );

   always_comb begin
      state_d  = state_q;
      width_d  = width_q;
      height_d = height_q;
      addr_d   = addr_q;
      pack_d   = pack_q;
      idx_d    = idx_q;
      wen_d    = wen_q;
      err_d    = err_q;

      if (wr_accept) begin
         wen_d  = 1'b0;
         addr_d = addr_q + ADDR_W'(1);
         pack_d = '0;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               if (dims_ok) begin
                  width_d  = img_width;
                  height_d = img_height;
                  addr_d   = base_addr;
                  pack_d   = '0;
                  idx_d    = '0;
                  err_d    = 1'b0;
                  state_d  = LOAD;
               end else begin
                  err_d    = 1'b1;
                  state_d  = DONE;
               end
            end
         end
         LOAD: begin
            if (pix_accept) begin
               for (int i = 0; i < PIX_PER_WORD; i++) begin
                  if (idx_q == IDX_W'(i)) pack_d[i*PIX_W +: PIX_W] = pix_data;
               end
               // a partial final word goes out as-is; its unused lanes are still zero
               if ((idx_q == IDX_LAST) || last_pix) begin
                  wen_d = 1'b1;
                  idx_d = '0;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
               if (last_pix) state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (wr_accept) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         width_q  <= '0;
         height_q <= '0;
         addr_q   <= '0;
         pack_q   <= '0;
         idx_q    <= '0;
         wen_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         width_q  <= width_d;
         height_q <= height_d;
         addr_q   <= addr_d;
         pack_q   <= pack_d;
         idx_q    <= idx_d;
         wen_q    <= wen_d;
         err_q    <= err_d;
      end
   end

   assign sram_wen   = wen_q;
   assign sram_addr  = addr_q;
   assign sram_wdata = pack_q;
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign err_size   = done && err_q;

endmodule
